// File: rtl/b_seq_pkg.sv
// Shared types and sizing for the beta-message RAM access sequencer.
// Beat counts follow from the layer size 2^L split into P-value read beats or 2P-value write beats.
package b_seq_pkg;

    localparam int P         = 32;
    localparam int N         = 1024;
    localparam int MAX_LAYER = $clog2(N / 4);
    localparam int CNT_W     = $clog2(N / (4 * P));
    localparam int LAYER_W   = 5;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    // Beats needed to move 2^layer values, at least one; out-of-range layers count as one.
    function automatic int unsigned beats_of(input logic [LAYER_W-1:0] layer, input int unsigned per);
        int unsigned vals;
        if (layer > LAYER_W'(MAX_LAYER)) begin
            vals = 32'd1;
        end else begin
            vals = 32'd1 << layer;
        end
        if (vals <= per) begin
            return 32'd1;
        end else begin
            return vals / per;
        end
    endfunction

    function automatic int unsigned wr_beats(input logic [LAYER_W-1:0] layer);
        return beats_of(layer, 32'(2 * P));
    endfunction

    function automatic int unsigned rd_beats(input logic [LAYER_W-1:0] layer);
        return beats_of(layer, 32'(P));
    endfunction

endpackage

// File: rtl/b_ram_seq.sv
// Layer-level request sequencer driving the beta RAM write/read ports with aligned read valid.
// Optional macro B_SEQ_RAW_CHECK_EN rejects reads of layers that have not been written since reset.
module b_ram_seq
    import b_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [LAYER_W-1:0] req_layer,
    output logic               req_err,
    input  logic               wr_beat_valid,
    output logic               wr_beat_ready,
    output logic               wr_last,
    output logic [LAYER_W-1:0] layer_w,
    output logic [LAYER_W-1:0] cnta,
    output logic               w_en,
    output logic [LAYER_W-1:0] layer_r,
    output logic [LAYER_W-1:0] cntb,
    output logic               r_en,
    output logic               rd_valid,
    output logic               rd_last,
    output logic               op_done
);

    state_e             state_r;
    logic [LAYER_W-1:0] lat_layer_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   last_idx_r;
    logic               rd_valid_r;
    logic               rd_last_r;
    logic               op_done_r;
    logic               req_err_r;

    logic               raw_ok_s;
    logic               legal_s;
    logic [CNT_W-1:0]   last_idx_s;
    logic               cnt_last_s;
    logic               req_ready_s;
    logic               wr_beat_ready_s;
    logic               w_en_s;
    logic               r_en_s;
    logic [LAYER_W-1:0] layer_w_s;
    logic [LAYER_W-1:0] layer_r_s;
    logic [LAYER_W-1:0] cnta_s;
    logic [LAYER_W-1:0] cntb_s;

`ifdef B_SEQ_RAW_CHECK_EN
    logic [MAX_LAYER-1:0] written_r;

    // Read-after-write guard: a write request is always fine, a read needs its layer bit set.
    always_comb begin
        raw_ok_s = req_write;
        for (int i = 1; i <= MAX_LAYER; i++) begin
            raw_ok_s = raw_ok_s | ((req_layer == LAYER_W'(i)) & written_r[i-1]);
        end
    end

    // Record each layer whose write completed; only reset clears the record.
    always_ff @(posedge clk) begin
        if (rst) begin
            written_r <= {MAX_LAYER{1'b0}};
        end else if (w_en_s && cnt_last_s) begin
            for (int i = 1; i <= MAX_LAYER; i++) begin
                if (lat_layer_r == LAYER_W'(i)) begin
                    written_r[i-1] <= 1'b1;
                end
            end
        end
    end
`else
    assign raw_ok_s = 1'b1;
`endif

    assign legal_s    = (req_layer != {LAYER_W{1'b0}}) && (req_layer <= LAYER_W'(MAX_LAYER)) && raw_ok_s;
    assign last_idx_s = req_write ? CNT_W'(wr_beats(req_layer) - 32'd1)
                                  : CNT_W'(rd_beats(req_layer) - 32'd1);
    assign cnt_last_s = (cnt_r == last_idx_r);

    // Port strobes decoded from state; everything outside its active state is zero.
    always_comb begin
        req_ready_s     = 1'b0;
        wr_beat_ready_s = 1'b0;
        w_en_s          = 1'b0;
        r_en_s          = 1'b0;
        layer_w_s       = {LAYER_W{1'b0}};
        layer_r_s       = {LAYER_W{1'b0}};
        cnta_s          = {LAYER_W{1'b0}};
        cntb_s          = {LAYER_W{1'b0}};
        case (state_r)
            IDLE: begin
                req_ready_s = ~rst;
            end
            WRITE: begin
                wr_beat_ready_s = 1'b1;
                w_en_s          = wr_beat_valid;
                layer_w_s       = lat_layer_r;
                cnta_s          = {{(LAYER_W-CNT_W){1'b0}}, cnt_r};
            end
            READ: begin
                r_en_s    = 1'b1;
                layer_r_s = lat_layer_r;
                cntb_s    = {{(LAYER_W-CNT_W){1'b0}}, cnt_r};
            end
            default: begin
                req_ready_s = 1'b0;
            end
        endcase
    end

    // FSM, beat counter, and the pulses delayed one cycle to line up with the RAM's registered read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            lat_layer_r <= {LAYER_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            last_idx_r  <= {CNT_W{1'b0}};
            rd_valid_r  <= 1'b0;
            rd_last_r   <= 1'b0;
            op_done_r   <= 1'b0;
            req_err_r   <= 1'b0;
        end else begin
            rd_valid_r <= r_en_s;
            rd_last_r  <= r_en_s & cnt_last_s;
            op_done_r  <= 1'b0;
            req_err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        if (legal_s) begin
                            lat_layer_r <= req_layer;
                            cnt_r       <= {CNT_W{1'b0}};
                            last_idx_r  <= last_idx_s;
                            state_r     <= req_write ? WRITE : READ;
                        end else begin
                            req_err_r <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (w_en_s) begin
                        if (cnt_last_s) begin
                            state_r   <= IDLE;
                            cnt_r     <= {CNT_W{1'b0}};
                            op_done_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end
                READ: begin
                    if (cnt_last_s) begin
                        state_r   <= IDLE;
                        cnt_r     <= {CNT_W{1'b0}};
                        op_done_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_s;
    assign req_err       = req_err_r;
    assign wr_beat_ready = wr_beat_ready_s;
    assign wr_last       = w_en_s & cnt_last_s;
    assign layer_w       = layer_w_s;
    assign cnta          = cnta_s;
    assign w_en          = w_en_s;
    assign layer_r       = layer_r_s;
    assign cntb          = cntb_s;
    assign r_en          = r_en_s;
    assign rd_valid      = rd_valid_r;
    assign rd_last       = rd_last_r;
    assign op_done       = op_done_r;

endmodule

// File: tb/tb_b_ram_seq.sv
// Bench for b_ram_seq: a cycle-indexed expectation table built from layer sizes and timing rules,
// checked every cycle, plus literal pins on key cycles. Honours B_SEQ_RAW_CHECK_EN.
module tb_b_ram_seq;

    typedef struct packed {
        logic       req_ready;
        logic       req_err;
        logic       wr_beat_ready;
        logic       wr_last;
        logic [4:0] layer_w;
        logic [4:0] cnta;
        logic       w_en;
        logic [4:0] layer_r;
        logic [4:0] cntb;
        logic       r_en;
        logic       rd_valid;
        logic       rd_last;
        logic       op_done;
    } outv_t;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } pin_t;

    localparam int MAXC = 512;
    localparam int S_W_EN = 0, S_CNTA = 1, S_WR_LAST = 2, S_OP_DONE = 3, S_R_EN = 4,
                   S_CNTB = 5, S_RD_LAST = 6, S_RD_VALID = 7, S_REQ_ERR = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [4:0] req_layer = 5'd0;
    logic       req_err;
    logic       wr_beat_valid = 1'b0;
    logic       wr_beat_ready;
    logic       wr_last;
    logic [4:0] layer_w;
    logic [4:0] cnta;
    logic       w_en;
    logic [4:0] layer_r;
    logic [4:0] cntb;
    logic       r_en;
    logic       rd_valid;
    logic       rd_last;
    logic       op_done;

    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    bit    check_on = 1'b0;
    outv_t exp_q [0:MAXC-1];
    pin_t  pins[$];
`ifdef B_SEQ_RAW_CHECK_EN
    bit    written [0:15];
`endif

    b_ram_seq dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_layer(req_layer), .req_err(req_err),
        .wr_beat_valid(wr_beat_valid), .wr_beat_ready(wr_beat_ready), .wr_last(wr_last),
        .layer_w(layer_w), .cnta(cnta), .w_en(w_en), .layer_r(layer_r), .cntb(cntb),
        .r_en(r_en), .rd_valid(rd_valid), .rd_last(rd_last), .op_done(op_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Layer of 2^l values: 2P=64 values per write beat, P=32 per read beat, never fewer than one.
    function automatic int mwb(input int l);
        int v;
        v = (1 << l) / 64;
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int mrb(input int l);
        int v;
        v = (1 << l) / 32;
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int sig_val(input int s);
        case (s)
            S_W_EN:     return int'(w_en);
            S_CNTA:     return int'(cnta);
            S_WR_LAST:  return int'(wr_last);
            S_OP_DONE:  return int'(op_done);
            S_R_EN:     return int'(r_en);
            S_CNTB:     return int'(cntb);
            S_RD_LAST:  return int'(rd_last);
            S_RD_VALID: return int'(rd_valid);
            S_REQ_ERR:  return int'(req_err);
            default:    return -1;
        endcase
    endfunction

    task automatic pin(input int c, input int s, input int v);
        pin_t p;
        p.cyc = c;
        p.sig = s;
        p.val = v;
        pins.push_back(p);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic v);
        repeat (n) begin
            wr_beat_valid = v;
            next_cycle();
        end
        wr_beat_valid = 1'b0;
    endtask

    // Issue one request in the current cycle, write its expected outputs into the table and
    // return in the cycle op_done (or req_err, or the post-abort cycle) is due.
    task automatic do_req(input bit wr, input int l, input logic [31:0] vpat, input int abort_beat);
        int  t, c, n, i, nb, lim;
        bit  ok;
        t  = cyc;
        ok = (l >= 1) && (l <= 8);
`ifdef B_SEQ_RAW_CHECK_EN
        if (ok && !wr && !written[l]) ok = 1'b0;
`endif
        req_valid = 1'b1;
        req_write = wr;
        req_layer = 5'(l);
        if (!ok) exp_q[t+1].req_err = 1'b1;
        next_cycle();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_layer = 5'd0;
        if (!ok) return;
        if (wr) begin
            n = 0;
            i = 0;
            c = t + 1;
            while (n < mwb(l) && i < 32) begin
                exp_q[c].req_ready     = 1'b0;
                exp_q[c].wr_beat_ready = 1'b1;
                exp_q[c].layer_w       = 5'(l);
                exp_q[c].cnta          = 5'(n);
                wr_beat_valid = vpat[i];
                if (vpat[i]) begin
                    exp_q[c].w_en    = 1'b1;
                    exp_q[c].wr_last = (n == mwb(l) - 1);
                    n++;
                end
                next_cycle();
                c++;
                i++;
            end
            wr_beat_valid = 1'b0;
            exp_q[c].op_done = 1'b1;
`ifdef B_SEQ_RAW_CHECK_EN
            written[l] = 1'b1;
`endif
        end else begin
            nb  = mrb(l);
            lim = (abort_beat < 0) ? nb : abort_beat + 1;
            for (int k = 0; k < lim; k++) begin
                exp_q[t+1+k].req_ready = 1'b0;
                exp_q[t+1+k].r_en      = 1'b1;
                exp_q[t+1+k].layer_r   = 5'(l);
                exp_q[t+1+k].cntb      = 5'(k);
                if (abort_beat < 0 || k < abort_beat) exp_q[t+2+k].rd_valid = 1'b1;
            end
            if (abort_beat < 0) begin
                exp_q[t+1+nb].rd_last = 1'b1;
                exp_q[t+1+nb].op_done = 1'b1;
                repeat (nb) next_cycle();
            end else begin
                repeat (abort_beat) next_cycle();
                rst = 1'b1;
                next_cycle();
                rst = 1'b0;
`ifdef B_SEQ_RAW_CHECK_EN
                for (int j = 0; j < 16; j++) written[j] = 1'b0;
`endif
            end
        end
    endtask

    // Whole-output comparison against the table every cycle, plus any literal pins due now.
    always @(negedge clk) begin
        outv_t got;
        if (check_on && cyc < MAXC) begin
            got.req_ready     = req_ready;
            got.req_err       = req_err;
            got.wr_beat_ready = wr_beat_ready;
            got.wr_last       = wr_last;
            got.layer_w       = layer_w;
            got.cnta          = cnta;
            got.w_en          = w_en;
            got.layer_r       = layer_r;
            got.cntb          = cntb;
            got.r_en          = r_en;
            got.rd_valid      = rd_valid;
            got.rd_last       = rd_last;
            got.op_done       = op_done;
            n_tests++;
            if (got !== exp_q[cyc]) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d got=%h expected=%h", cyc, got, exp_q[cyc]);
            end
            foreach (pins[j]) begin
                if (pins[j].cyc == cyc) begin
                    n_tests++;
                    if (sig_val(pins[j].sig) != pins[j].val) begin
                        n_fail++;
                        $display("FAIL pin sig%0d cyc=%0d got=%0d expected=%0d",
                                 pins[j].sig, cyc, sig_val(pins[j].sig), pins[j].val);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int c = 0; c < MAXC; c++) begin
            exp_q[c] = '0;
            exp_q[c].req_ready = 1'b1;
        end
        exp_q[1].req_ready = 1'b0;
        exp_q[2].req_ready = 1'b0;
`ifdef B_SEQ_RAW_CHECK_EN
        for (int j = 0; j < 16; j++) written[j] = 1'b0;
`endif
        next_cycle();
        check_on = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        idle(2, 1'b0);

        t = cyc;
        pin(t+1, S_W_EN, 1); pin(t+4, S_WR_LAST, 1); pin(t+4, S_CNTA, 3); pin(t+5, S_OP_DONE, 1);
        do_req(1'b1, 8, 32'hFFFF_FFFF, -1);

        t = cyc;
        pin(t+1, S_W_EN, 0); pin(t+2, S_CNTA, 0); pin(t+3, S_CNTA, 1); pin(t+3, S_W_EN, 1);
        pin(t+4, S_OP_DONE, 1);
        do_req(1'b1, 7, 32'h0000_0006, -1);

        t = cyc;
        pin(t+1, S_CNTB, 0); pin(t+8, S_CNTB, 7); pin(t+9, S_RD_LAST, 1); pin(t+9, S_OP_DONE, 1);
        pin(t+9, S_RD_VALID, 1); pin(t+10, S_RD_VALID, 0);
        do_req(1'b0, 8, 32'h0, -1);

        t = cyc;
        pin(t+1, S_R_EN, 1); pin(t+2, S_R_EN, 0); pin(t+2, S_RD_LAST, 1);
        do_req(1'b0, 3, 32'h0, -1);
        idle(2, 1'b1);

        t = cyc;
        pin(t+1, S_REQ_ERR, 1); pin(t+1, S_W_EN, 0);
        do_req(1'b1, 0, 32'hFFFF_FFFF, -1);
        do_req(1'b0, 9, 32'h0, -1);
        idle(2, 1'b0);

        do_req(1'b0, 6, 32'h0, -1);
        idle(1, 1'b0);
        do_req(1'b1, 6, 32'hFFFF_FFFF, -1);
        do_req(1'b0, 6, 32'h0, -1);
        do_req(1'b1, 1, 32'hFFFF_FFFF, -1);
        do_req(1'b0, 1, 32'h0, -1);
        idle(2, 1'b0);

        t = cyc;
        pin(t+3, S_R_EN, 1); pin(t+4, S_R_EN, 0); pin(t+4, S_RD_VALID, 0); pin(t+4, S_OP_DONE, 0);
        do_req(1'b0, 8, 32'h0, 2);
        do_req(1'b0, 5, 32'h0, -1);
        idle(2, 1'b0);

        do_req(1'b1, 8, 32'h0000_1451, -1);
        do_req(1'b0, 7, 32'h0, -1);
        idle(4, 1'b1);

        check_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/b_ram_seq.md
Name: b_ram_seq

Overview:
- Access sequencer that drives the read and write ports of the beta-message layer RAM in the SCAN polar decoder.
- Accepts one layer-level request at a time: write a whole layer, or read a whole layer.
- Expands each request into per-beat layer_w/cnta/w_en or layer_r/cntb/r_en strobes.
- Tracks the RAM's registered 1-cycle read latency and produces aligned rd_valid/rd_last plus op_done.

Parameters:
- P, 32, LLR/beta values per read beat; a write beat carries 2P values.
- N, 1024, code length; highest stored layer is log2(N/4) = 8.
- MAX_LAYER, 8, highest legal layer index; legal layers are 1..MAX_LAYER.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  sequencer idle and able to accept a request
- req_write  in  1  1 = write layer, 0 = read layer
- req_layer  in  5  target layer
- req_err  out  1  1-cycle pulse: accepted request rejected
- wr_beat_valid  in  1  producer has a 2P-value beat on the RAM data input
- wr_beat_ready  out  1  sequencer consuming write beats
- wr_last  out  1  current write handshake is the final beat
- layer_w  out  5  to RAM write layer
- cnta  out  5  to RAM write count
- w_en  out  1  to RAM write enable
- layer_r  out  5  to RAM read layer
- cntb  out  5  to RAM read count
- r_en  out  1  to RAM read enable
- rd_valid  out  1  RAM read data valid this cycle
- rd_last  out  1  final read beat valid this cycle
- op_done  out  1  1-cycle pulse: request complete

Behaviour:
- Reset: rst is synchronous active-high. All outputs are 0 except req_ready, which is 0 during rst and 1 in the first cycle after it. FSM goes to IDLE and counters clear. Asserting rst mid-operation aborts immediately: no further strobes and no op_done.
- Layer size is 2^L values.
  - Write beats WB(L) = max(1, 2^L/(2P)).
  - Read beats RB(L) = max(1, 2^L/P).
  - For P=32: WB = 4/2/1 for L = 8/7/≤6; RB = 8/4/2/1 for L = 8/7/6/≤5.
- FSM has three states: IDLE, WRITE, READ.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready with a legal layer, latch the layer, clear the beat counter, and enter WRITE or READ.
  - If the layer is illegal (0 or >MAX_LAYER), the request is consumed: req_err pulses the next cycle and the FSM stays in IDLE.
- WRITE:
  - wr_beat_ready=1, layer_w=latched layer, cnta=beat counter (zero-extended).
  - w_en = wr_beat_valid, so the producer can stall indefinitely with no write issued.
  - The counter increments on each w_en. wr_last = w_en & (cnt == WB-1).
  - On the last beat: next state IDLE, and op_done pulses the following cycle.
- READ:
  - r_en=1 every cycle with no backpressure; layer_r=latched layer, cntb=beat counter.
  - After RB beats, return to IDLE.
  - rd_valid and rd_last are r_en and the last-beat flag delayed by 1 register, matching the RAM's registered output.
  - op_done pulses coincident with rd_last.
- Outside its active state, each strobe and layer/count output is 0. Layer 0 on the read port makes the RAM output zeros.
- A new request may be accepted in the cycle op_done is high, i.e. back-to-back with no dead cycle after return to IDLE. Read data of the previous op is still emerging that cycle and remains correct.
- Timing from acceptance at cycle t:
  - First strobe at t+1.
  - Read: first rd_valid at t+2, last at t+1+RB.
  - Write with no stalls: op_done at t+1+WB.

Optional Feature:
- Macro: B_SEQ_RAW_CHECK_EN.
- Defined:
  - Keep a MAX_LAYER-bit written mask. It is cleared by rst, and bit L is set on completion of a write to layer L.
  - A read request to a layer whose bit is clear is rejected exactly like an illegal layer (req_err pulse, no r_en).
- Undefined: no mask exists, and any legal layer may be read.

Decomposition:
- Package b_seq_pkg holds:
  - the state enum (IDLE/WRITE/READ);
  - a localparam for MAX_LAYER derived from N;
  - functions wr_beats(layer) and rd_beats(layer) parameterised by P;
  - the counter width clog2(N/(4P)).
- No sub-module is needed; the beat-count functions replace a lookup sub-block.

Test Plan:
- rst held 3 cycles then released -> all strobes 0 during rst; req_ready=1 in the first cycle after release.
- Write L=8, wr_beat_valid always 1, accepted at t -> w_en at t+1..t+4 with cnta 0,1,2,3; wr_last at t+4; op_done at t+5.
- Write L=7 with wr_beat_valid low at t+1, high at t+2,t+3 -> w_en only at t+2 (cnta=0) and t+3 (cnta=1); op_done at t+4.
- Read L=8 at t -> r_en t+1..t+8, cntb 0..7; rd_valid t+2..t+9; rd_last and op_done at t+9. Read L=3 -> single r_en at t+1, cntb=0, rd_last at t+2.
- Request L=0 and L=9 -> req_err pulse, no w_en/r_en, req_ready stays 1. Macro defined: read L=6 after rst -> req_err; after a write of L=6 -> 2 read beats.
- rst asserted at the third beat of a L=8 read -> r_en=0 and rd_valid=0 from the next cycle, no op_done; a new L=5 read then completes in 1 beat.
